// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op select, FSM states
// and the funct codes the decoder uses to steer MULTU/DIVU/MFHI/MFLO/MTHI/MTLO.
package hilo_muldiv_unit_pkg;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One-bit-per-cycle shift-add multiply / restoring divide datapath on a shared 2*WIDTH accumulator.
// load captures operands; each step advances one iteration; {hi_next, lo_next} is the post-step value.
module muldiv_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic               op_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    // Divide borrow is diff[WIDTH]: remainder < divisor keeps a non-borrowing diff below 2^WIDTH.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, opnd};
        acc_step = acc;
        if (op_q == OP_MULTU) begin
            if (acc[0]) acc_step = {sum, acc[WIDTH-1:1]};
            else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= OP_MULTU;
            opnd <= '0;
            acc  <= '0;
        end else if (load) begin
            op_q <= op;
            opnd <= (op == OP_MULTU) ? a : b;
            acc  <= {{WIDTH{1'b0}}, ((op == OP_MULTU) ? b : a)};
        end else if (step) begin
            acc <= acc_step;
        end
    end

    assign hi_next = acc_step[2*WIDTH-1:WIDTH];
    assign lo_next = acc_step[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULTU/DIVU owning HI/LO; result lands WIDTH edges after start, done pulses one cycle after.
// busy stalls the PC; start and MTHI/MTLO are ignored while an operation runs.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    assign accept = start && (state != RUN);

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (state == RUN),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // An mt-write on the accept edge lands now; the result overwrites it later.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    cnt <= '0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        hi    <= hi_next;
                        lo    <= lo_next;
                        cnt   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed table-driven bench for hilo_muldiv_unit plus hand sequences for the multi-cycle corners.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    endtask

    task automatic wait_done(input string nm, output int bc);
        int cyc;
        bc  = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) bc++;
            cyc++;
            @(negedge clk);
        end
        check({nm, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic do_op(input vec_t v);
        int bc;
        launch(v.op, v.a, v.b);
        wait_done(v.nm, bc);
        check({v.nm, "_busy_cycles"}, 64'(bc), 64'd32);
        check({v.nm, "_hi"}, 64'(hi), 64'(v.eh));
        check({v.nm, "_lo"}, 64'(lo), 64'(v.el));
        @(negedge clk);
        check({v.nm, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          bc;
        int          dcount;
        logic [31:0] hprev;
        logic [31:0] lprev;

        tbl[0]  = '{"mul_max",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{"mul_3x5",     1'b0, 32'd3,        32'd5,        32'h0,        32'd15};
        tbl[2]  = '{"div_100_7",   1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[3]  = '{"div_by_zero", 1'b1, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF};
        tbl[4]  = '{"mul_carry",   1'b0, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE};
        tbl[5]  = '{"mul_shift",   1'b0, 32'h12345678, 32'h10,       32'h1,        32'h23456780};
        tbl[6]  = '{"mul_zero",    1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
        tbl[7]  = '{"div_by_one",  1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF};
        tbl[8]  = '{"div_small",   1'b1, 32'd5,        32'd10,       32'd5,        32'd0};
        tbl[9]  = '{"div_by_16",   1'b1, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
        tbl[10] = '{"div_big_rem", 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
        tbl[11] = '{"div_equal",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1};

        // Reset held with random inputs.
        reset = 1'b0;
        start = 1'($urandom); op = 1'($urandom); a = $urandom; b = $urandom;
        hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_hi", 64'(hi), 64'd0);
        check("idle_lo", 64'(lo), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        foreach (tbl[i]) do_op(tbl[i]);

        // start and mt-write during RUN are ignored.
        hprev = hi; lprev = lo;
        launch(1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000DEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("run_hi_stable", 64'(hi), 64'(hprev));
        check("run_lo_stable", 64'(lo), 64'(lprev));
        check("run_busy", 64'(busy), 64'd1);
        wait_done("intf", bc);
        check("intf_busy_left", 64'(bc), 64'd22);
        check("intf_hi", 64'(hi), 64'd2);
        check("intf_lo", 64'(lo), 64'd14);

        // Start accepted in the done cycle.
        start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("chain_busy", 64'(busy), 64'd1);
        check("chain_done_low", 64'(done), 64'd0);
        wait_done("chain", bc);
        check("chain_busy_cycles", 64'(bc), 64'd32);
        check("chain_hi", 64'(hi), 64'd0);
        check("chain_lo", 64'(lo), 64'd42);
        @(negedge clk);

        // MTHI/MTLO in IDLE.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_hi", 64'(hi), 64'hA5A5A5A5);
        check("mt_lo", 64'(lo), 64'hA5A5A5A5);

        // mt-write on the accept edge lands, then the result overwrites it.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5; hi_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("mt_at_start_hi", 64'(hi), 64'h1234);
        check("mt_at_start_lo", 64'(lo), 64'hA5A5A5A5);
        wait_done("mtstart", bc);
        check("mtstart_hi", 64'(hi), 64'd0);
        check("mtstart_lo", 64'(lo), 64'd15);
        @(negedge clk);

        // Reset mid-operation discards the in-flight result.
        launch(1'b1, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) dcount++;
            @(negedge clk);
        end
        check("midrst_quiet", 64'(dcount), 64'd0);
        do_op('{"div_1000_3", 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle unsigned multiply/divide unit that owns the architectural HI/LO registers. It sits directly downstream of register-file operand read (srca/srcb) and upstream of the result mux. It executes MULTU/DIVU iteratively, raises busy so the program counter can stall, and supplies HI/LO for MFHI/MFLO. It also accepts MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand and HI/LO width in bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset (reset==0 at a posedge clears state).
start  in  1  request a new operation; sampled only when accepting (IDLE or DONE).
op  in  1  0 = MULTU, 1 = DIVU; sampled with start.
a  in  WIDTH  operand rs (multiplicand / dividend); sampled with start.
b  in  WIDTH  operand rt (multiplier / divisor); sampled with start.
hi_we  in  1  MTHI write enable.
lo_we  in  1  MTLO write enable.
wdata  in  WIDTH  MTHI/MTLO data.
busy  out  1  operation in progress; PC stall request.
done  out  1  one-cycle pulse; HI/LO hold the new result.
hi  out  WIDTH  HI register (product high / remainder).
lo  out  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, internal shift registers=0. Reset wins over every other input, including mid-operation; any in-flight result is discarded.
- FSM states:
  - IDLE: busy=0, done=0. start=1 -> latch op/a/b, counter=0, go RUN.
  - RUN: busy=1. One iteration per cycle, counter++. When counter==WIDTH-1 at the edge, write HI/LO and go DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 -> accept as in IDLE and go RUN; otherwise go IDLE.
- Latency: start accepted at edge E0. busy=1 for the WIDTH cycles following E0. HI/LO are updated at edge E0+WIDTH, and done is high in the cycle after that edge. Default latency is 32 cycles.
- MULTU: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle. Result {hi,lo} = a*b, unsigned, full 64 bits, no truncation.
- DIVU: restoring division, one quotient bit per cycle. lo = a/b, hi = a%b, unsigned.
- Divide by zero: no trap, fixed latency. Required result: lo = all ones, hi = a. This is the natural restoring-algorithm outcome and must be preserved.
- start while in RUN: ignored; busy already stalls the pipeline. No queueing.
- hi_we/lo_we:
  - In IDLE or DONE: write wdata into the selected register at that edge. Both writes may occur in the same cycle.
  - In RUN: ignored, with no side effect.
  - Same edge as an accepted start: the write takes effect, and the operation result later overwrites it at completion.
- hi/lo outputs are registered and change only on reset, an accepted mt-write, or completion. They are stable during RUN and hold their previous values until completion.
- Operands are captured at start; a/b changing during RUN has no effect.

Decomposition:
- Shared package holds:
  - op encodings OP_MULTU=1'b0, OP_DIVU=1'b1;
  - FSM state typedef {IDLE, RUN, DONE};
  - funct constants 6'b011001 (MULTU), 6'b011011 (DIVU), 6'b010000 (MFHI), 6'b010010 (MFLO), 6'b010001 (MTHI), 6'b010011 (MTLO) for the decoder.
- One sub-module is natural: muldiv_iter_core. It contains the per-cycle shift-add / restoring-subtract datapath with load/step inputs and {hi_next, lo_next} outputs.
- The FSM, counter and HI/LO registers stay in the top module.

Test Plan:
- Hold reset=0 for 2 cycles with random inputs -> hi=0, lo=0, busy=0, done=0; release, idle 5 cycles -> all outputs unchanged.
- start, op=MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy=1 for 32 cycles, done pulses once, hi=0xFFFFFFFE, lo=0x00000001. Then MULTU 3*5 -> hi=0, lo=15.
- start, op=DIVU, a=100, b=7 -> after 32 cycles lo=14, hi=2. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, same latency.
- DIVU 100/7 in flight; at cycle 10 pulse start (MULTU 2*2) and hi_we with wdata=0xDEAD -> both ignored, result still lo=14, hi=2, single done pulse.
- In the done cycle, assert start MULTU 6*7 -> accepted immediately, busy next cycle, hi=0, lo=42 after 32 cycles. In IDLE, hi_we=1, lo_we=1, wdata=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 the next cycle.
- Start DIVU 1000/3; drive reset=0 at cycle 15 for one edge -> busy=0, hi=lo=0, no done pulse; a fresh DIVU 1000/3 then yields lo=333, hi=1.
